// File: rtl/comb_seq_pkg.sv
// comb_seq_pkg: shared state encoding, LFSR polynomial and default seed for comb_vector_seq.
package comb_seq_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, DONE} state_t;
    // x^16+x^14+x^13+x^11+1 as taps on q[15], q[13], q[12], q[10]
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/seq_lfsr16.sv
// seq_lfsr16: 16-bit Fibonacci LFSR with parallel load and XOR inject (generator or MISR).
module seq_lfsr16 import comb_seq_pkg::*; #(
    parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic [15:0] inj,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RST_VAL;
        else if (load) q <= load_val;
        else if (en) q <= lfsr_next(q) ^ inj;
endmodule

// File: rtl/comb_vector_seq.sv
// comb_vector_seq: LFSR vector sequencer with MISR response compaction for a combinational netlist.
// Optional golden-signature compare enabled by COMB_SEQ_GOLDEN_CMP_EN. N_IN and N_OUT must be <= 16.
module comb_vector_seq import comb_seq_pkg::*; #(
    parameter int N_IN       = 14,
    parameter int N_OUT      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_pat_i,
    input  logic [15:0]      seed_i,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      sig_o,
    output logic [CNT_W-1:0] pat_cnt_o
`ifdef COMB_SEQ_GOLDEN_CMP_EN
    ,
    input  logic [15:0]      golden_i,
    output logic             pass_o
`endif
);
    state_t           state;
    logic [3:0]       settle_cnt;
    logic [CNT_W-1:0] num_q, cnt_nxt;
    logic [15:0]      seed_eff, gen_q, gen_nxt;
    logic             go, run, cap, last;
    assign go       = state == IDLE && start_i;
    assign run      = go && num_pat_i != '0;
    assign cap      = state == CAPTURE && !abort_i;
    assign cnt_nxt  = pat_cnt_o + 1'b1;
    // all-ones count also ends the run so the counter never wraps
    assign last     = cnt_nxt == num_q || &cnt_nxt;
    assign seed_eff = seed_i == '0 ? DEFAULT_SEED : seed_i;
    assign gen_nxt  = lfsr_next(gen_q);
    assign busy_o   = state != IDLE;
    assign done_o   = state == DONE;
    seq_lfsr16 #(.RST_VAL(DEFAULT_SEED)) u_gen (
        .clk(clk), .rst_n(rst_n), .load(run), .load_val(seed_eff),
        .en(cap), .inj(16'h0000), .q(gen_q)
    );
    seq_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
        .clk(clk), .rst_n(rst_n), .load(go), .load_val(16'h0000),
        .en(cap), .inj(16'(resp_i)), .q(sig_o)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            num_q      <= '0;
            pat_cnt_o  <= '0;
            vec_o      <= '0;
        end else if (state != IDLE && abort_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    num_q     <= num_pat_i;
                    pat_cnt_o <= '0;
                    state     <= run ? APPLY : DONE;
                    if (run) vec_o <= seed_eff[N_IN-1:0];
                end
                APPLY: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == 4'(SETTLE_CYC - 1)) state <= CAPTURE;
                end
                CAPTURE: begin
                    pat_cnt_o <= cnt_nxt;
                    state     <= last ? DONE : APPLY;
                    if (!last) vec_o <= gen_nxt[N_IN-1:0];
                end
                default: state <= IDLE;
            endcase
        end
`ifdef COMB_SEQ_GOLDEN_CMP_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pass_o <= 1'b0;
        else if (state == DONE && !abort_i) pass_o <= sig_o == golden_i;
        else if (go) pass_o <= 1'b0;
`endif
endmodule

// File: tb/tb_comb_vector_seq.sv
// tb_comb_vector_seq: directed self-checking bench for comb_vector_seq (default parameters).
// Golden-compare checks are included when COMB_SEQ_GOLDEN_CMP_EN is defined.
module tb_comb_vector_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [15:0] num, seed, sig;
    logic [13:0] vec;
    logic [7:0]  resp;
    logic        busy, done;
    logic [15:0] cnt;
    int          checks = 0;
    int          errors = 0;
`ifdef COMB_SEQ_GOLDEN_CMP_EN
    logic [15:0] golden;
    logic        pass;
`endif
    always #5 clk = ~clk;
    comb_vector_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .num_pat_i(num), .seed_i(seed), .vec_o(vec), .resp_i(resp),
        .busy_o(busy), .done_o(done), .sig_o(sig), .pat_cnt_o(cnt)
`ifdef COMB_SEQ_GOLDEN_CMP_EN
        , .golden_i(golden), .pass_o(pass)
`endif
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic run_full(input logic [15:0] s, input logic [15:0] n, input logic [7:0] r,
                            input logic [15:0] exp_sig);
        int hit;
        seed = s; num = n; resp = r; start = 1'b1;
        tick();
        start = 1'b0;
        hit = -1;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (done) begin
                hit = e;
                break;
            end
        end
        check("run_done_edge", hit, 32'(n) * 4);
        check("run_sig", sig, exp_sig);
        check("run_cnt", cnt, n);
        tick();
        check("run_idle_after_done", {busy, done}, 2'b00);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num = '0; seed = '0; resp = '0;
`ifdef COMB_SEQ_GOLDEN_CMP_EN
        golden = 16'h0003;
`endif
        #12;
        check("rst_outputs", {vec, sig, cnt, busy, done}, '0);
`ifdef COMB_SEQ_GOLDEN_CMP_EN
        check("rst_pass", pass, 1'b0);
`endif
        @(negedge clk) rst_n = 1'b1;
        tick();
        // seed 1, two patterns, resp 0x01
        seed = 16'h0001; num = 16'd2; resp = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1'b1);
        check("t1_vec_p1", vec, 14'h0001);
        repeat (3) tick();
        check("t1_vec_hold_capture", vec, 14'h0001);
        check("t1_no_done_e3", done, 1'b0);
        tick();
        check("t1_vec_p2", vec, 14'h0002);
        check("t1_cnt_p1", cnt, 16'd1);
        check("t1_sig_p1", sig, 16'h0001);
        repeat (3) tick();
        check("t1_no_done_e7", done, 1'b0);
        tick();
        check("t1_done_e8", done, 1'b1);
        check("t1_sig", sig, 16'h0003);
        check("t1_cnt", cnt, 16'd2);
        tick();
        check("t1_done_one_cycle", {busy, done}, 2'b00);
        check("t1_vec_hold_idle", vec, 14'h0002);
`ifdef COMB_SEQ_GOLDEN_CMP_EN
        check("t1_pass_match", pass, 1'b1);
`endif
        // zero patterns
        num = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t0_done", {busy, done}, 2'b11);
        check("t0_sig_cnt", {sig, cnt}, 32'h0);
        tick();
        check("t0_idle", {busy, done}, 2'b00);
        // zero seed substitutes default
        seed = 16'h0000; num = 16'd1; resp = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_vec_default_seed", vec, 14'h2CE1);
        repeat (4) tick();
        check("t2_done", done, 1'b1);
        check("t2_sig", sig, 16'h0000);
        check("t2_cnt", cnt, 16'd1);
        tick();
`ifdef COMB_SEQ_GOLDEN_CMP_EN
        golden = 16'h0004;
        run_full(16'h0001, 16'd2, 8'h01, 16'h0003);
        check("t1_pass_mismatch", pass, 1'b0);
`endif
        // abort in SETTLE of pattern 3 of 10, with an ignored start mid-run
        seed = 16'h0001; num = 16'd10; resp = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; num = 16'd1; seed = 16'h0005;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("ab_cnt_before", cnt, 16'd2);
        check("ab_vec_p3", vec, 14'h0004);
        tick();
        check("ab_busy_settle", busy, 1'b1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("ab_idle", {busy, done}, 2'b00);
        check("ab_cnt_held", cnt, 16'd2);
        check("ab_sig_held", sig, 16'h0003);
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= done;
        end
        check("ab_no_done", seen, 1'b0);
        // reset mid-CAPTURE, then reproduce signature
        run_full(16'h1234, 16'd3, 8'h5A, 16'h0186);
        seed = 16'h1234; num = 16'd3; resp = 8'h5A; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_zero", {vec, sig, cnt, busy, done}, '0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("rs_no_resume", busy, 1'b0);
        run_full(16'h1234, 16'd3, 8'h5A, 16'h0186);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
